// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, flushes,
// operand forwarding, memory-wait tracking with timeout and perf counters.
module pipeline_hazard_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic [3:0]       exe_src1,
    input  logic [3:0]       exe_src2,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_all,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        timeout_nxt;
    logic        hazard;
    logic        m1, m2, n1, n2;

    function automatic logic [1:0] fwd_sel(input logic [3:0] src);
        if (mem_wb_en && mem_dest == src)
            return 2'b01;
        else if (wb_wb_en && wb_dest == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        m1 = exe_wb_en && exe_dest == id_src1;
        m2 = exe_wb_en && id_two_src && exe_dest == id_src2;
        n1 = mem_wb_en && mem_dest == id_src1;
        n2 = mem_wb_en && id_two_src && mem_dest == id_src2;
        if (forward_en)
            hazard = exe_mem_read && (m1 || m2);
        else
            hazard = m1 || m2 || n1 || n2;
    end

    // Every output is held low while reset is asserted.
    always_comb begin
        freeze_all   = rst && mem_req && !mem_ready;
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        sel_src1     = 2'b00;
        sel_src2     = 2'b00;
        if (rst) begin
            if (freeze_all) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
            end else if (branch_taken) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (hazard) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                flush_id_ex  = 1'b1;
            end
            if (forward_en) begin
                sel_src1 = fwd_sel(exe_src1);
                sel_src2 = fwd_sel(exe_src2);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = mem_timeout;
        unique case (state)
            RUN: begin
                if (freeze_all) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt == TMO)
                    timeout_nxt = 1'b1;
                if (!freeze_all) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end else if (wait_cnt != TMO) begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
            if (freeze_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_if_id && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with small counters and a
// short timeout so saturation and timeout paths are reachable quickly.
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 3;
    localparam int TMO   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             forward_en;
    logic [3:0]       id_src1, id_src2;
    logic             id_two_src;
    logic [3:0]       exe_dest;
    logic             exe_wb_en, exe_mem_read;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic [3:0]       wb_dest;
    logic             wb_wb_en;
    logic [3:0]       exe_src1, exe_src2;
    logic             branch_taken, mem_req, mem_ready;
    logic             freeze_pc, freeze_if_id, flush_if_id, flush_id_ex;
    logic             freeze_all, mem_timeout;
    logic [1:0]       sel_src1, sel_src2;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int passed = 0;
    int total  = 0;

    pipeline_hazard_controller #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .exe_src1(exe_src1), .exe_src2(exe_src2),
        .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .freeze_pc(freeze_pc),
        .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .freeze_all(freeze_all),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0;
        mem_dest = 0; mem_wb_en = 0; wb_dest = 0; wb_wb_en = 0;
        exe_src1 = 0; exe_src2 = 0; branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        tick();
        rst = 1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        forward_en = 1; exe_src1 = 7; mem_dest = 7; mem_wb_en = 1;
        mem_req = 1; branch_taken = 1;
        #1;
        total++;
        if ({freeze_all, freeze_pc, freeze_if_id, flush_if_id, flush_id_ex} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000",
                     {freeze_all, freeze_pc, freeze_if_id, flush_if_id, flush_id_ex});
        else passed++;
        total++;
        if (sel_src1 !== 2'b00)
            $display("FAIL reset_sel got %b want 00", sel_src1);
        else passed++;
        tick();
        total++;
        if ({stall_cnt, flush_cnt, mem_timeout} !== 7'b0)
            $display("FAIL reset_state got %b want 0000000",
                     {stall_cnt, flush_cnt, mem_timeout});
        else passed++;
    endtask

    task automatic test_stall_no_fwd();
        do_reset();
        exe_dest = 3; exe_wb_en = 1; id_src1 = 3;
        #1;
        total++;
        if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex} !== 4'b1101)
            $display("FAIL raw_stall got %b want 1101",
                     {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex});
        else passed++;
        total++;
        if (stall_cnt !== 3'd0)
            $display("FAIL raw_cnt0 got %0d want 0", stall_cnt);
        else passed++;
        tick();
        total++;
        if (stall_cnt !== 3'd1)
            $display("FAIL raw_cnt1 got %0d want 1", stall_cnt);
        else passed++;
        idle();
        mem_dest = 9; mem_wb_en = 1; id_src2 = 9; id_two_src = 1;
        #1;
        total++;
        if (freeze_pc !== 1'b1)
            $display("FAIL mem_src2_stall got %b want 1", freeze_pc);
        else passed++;
        id_two_src = 0;
        #1;
        total++;
        if (freeze_pc !== 1'b0)
            $display("FAIL one_src_nostall got %b want 0", freeze_pc);
        else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        forward_en = 1; exe_mem_read = 1; exe_wb_en = 1;
        exe_dest = 5; id_src2 = 5; id_two_src = 1;
        #1;
        total++;
        if ({freeze_pc, flush_id_ex} !== 2'b11)
            $display("FAIL load_use got %b want 11", {freeze_pc, flush_id_ex});
        else passed++;
        tick();
        exe_mem_read = 0;
        #1;
        total++;
        if ({freeze_pc, flush_id_ex} !== 2'b00)
            $display("FAIL fwd_nostall got %b want 00", {freeze_pc, flush_id_ex});
        else passed++;
        tick();
        total++;
        if (stall_cnt !== 3'd1)
            $display("FAIL load_use_cnt got %0d want 1", stall_cnt);
        else passed++;
        exe_wb_en = 0; mem_dest = 5; mem_wb_en = 1;
        #1;
        total++;
        if (freeze_pc !== 1'b0)
            $display("FAIL fwd_mem_nostall got %b want 0", freeze_pc);
        else passed++;
    endtask

    task automatic test_forwarding();
        do_reset();
        forward_en = 1; exe_src1 = 7; mem_dest = 7; mem_wb_en = 1;
        wb_dest = 7; wb_wb_en = 1; exe_src2 = 2;
        #1;
        total++;
        if (sel_src1 !== 2'b01)
            $display("FAIL sel1_exmem got %b want 01", sel_src1);
        else passed++;
        total++;
        if (sel_src2 !== 2'b00)
            $display("FAIL sel2_none got %b want 00", sel_src2);
        else passed++;
        mem_req = 1;
        #1;
        total++;
        if ({freeze_all, sel_src1} !== 3'b101)
            $display("FAIL sel_in_freeze got %b want 101", {freeze_all, sel_src1});
        else passed++;
        mem_req = 0; mem_wb_en = 0;
        #1;
        total++;
        if (sel_src1 !== 2'b10)
            $display("FAIL sel1_memwb got %b want 10", sel_src1);
        else passed++;
        wb_dest = 2;
        #1;
        total++;
        if ({sel_src1, sel_src2} !== 4'b0010)
            $display("FAIL sel2_memwb got %b want 0010", {sel_src1, sel_src2});
        else passed++;
        forward_en = 0;
        #1;
        total++;
        if ({sel_src1, sel_src2} !== 4'b0000)
            $display("FAIL sel_fwd_off got %b want 0000", {sel_src1, sel_src2});
        else passed++;
    endtask

    task automatic test_branch();
        do_reset();
        exe_dest = 4; exe_wb_en = 1; id_src1 = 4; branch_taken = 1;
        #1;
        total++;
        if ({freeze_pc, freeze_if_id, flush_if_id, flush_id_ex} !== 4'b0011)
            $display("FAIL branch_hazard got %b want 0011",
                     {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex});
        else passed++;
        tick();
        total++;
        if ({flush_cnt, stall_cnt} !== {3'd1, 3'd0})
            $display("FAIL branch_cnt got %0d/%0d want 1/0", flush_cnt, stall_cnt);
        else passed++;
        mem_req = 1; mem_ready = 0;
        #1;
        total++;
        if ({freeze_all, freeze_pc, flush_if_id, flush_id_ex} !== 4'b1100)
            $display("FAIL branch_in_freeze got %b want 1100",
                     {freeze_all, freeze_pc, flush_if_id, flush_id_ex});
        else passed++;
        tick();
        total++;
        if ({flush_cnt, stall_cnt} !== {3'd1, 3'd1})
            $display("FAIL freeze_cnt got %0d/%0d want 1/1", flush_cnt, stall_cnt);
        else passed++;
        mem_ready = 1;
        #1;
        total++;
        if ({freeze_all, flush_if_id, flush_id_ex} !== 3'b011)
            $display("FAIL branch_after_freeze got %b want 011",
                     {freeze_all, flush_if_id, flush_id_ex});
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        id_src1 = 6; exe_dest = 6; exe_wb_en = 1;
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (stall_cnt !== 3'd7)
            $display("FAIL stall_sat got %0d want 7", stall_cnt);
        else passed++;
        branch_taken = 1;
        for (int i = 0; i < 8; i++) tick();
        total++;
        if ({flush_cnt, stall_cnt} !== {3'd7, 3'd7})
            $display("FAIL flush_sat got %0d/%0d want 7/7", flush_cnt, stall_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        mem_req = 0;
        tick();
        mem_req = 1;
        #1;
        for (int i = 1; i <= 6; i++) begin
            total++;
            if (freeze_all !== 1'b1)
                $display("FAIL to_freeze%0d got %b want 1", i, freeze_all);
            else passed++;
            tick();
            total++;
            if (mem_timeout !== (i >= 5))
                $display("FAIL to_flag%0d got %b want %b", i, mem_timeout, i >= 5);
            else passed++;
        end
        mem_ready = 1;
        #1;
        total++;
        if ({freeze_all, freeze_pc} !== 2'b00)
            $display("FAIL to_release got %b want 00", {freeze_all, freeze_pc});
        else passed++;
        tick();
        total++;
        if ({mem_timeout, stall_cnt} !== {1'b1, 3'd7})
            $display("FAIL to_sticky got %b want 1111", {mem_timeout, stall_cnt});
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        forward_en = 1; exe_src1 = 8; mem_dest = 8; mem_wb_en = 1;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (mem_timeout !== 1'b1)
            $display("FAIL mid_pre_to got %b want 1", mem_timeout);
        else passed++;
        rst = 0;
        #1;
        total++;
        if ({freeze_all, freeze_pc, freeze_if_id, sel_src1, mem_timeout} !== 6'b0)
            $display("FAIL mid_rst_out got %b want 000000",
                     {freeze_all, freeze_pc, freeze_if_id, sel_src1, mem_timeout});
        else passed++;
        total++;
        if ({stall_cnt, flush_cnt} !== 6'b0)
            $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else passed++;
        tick();
        rst = 1;
        #1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (mem_timeout !== (i >= 5))
                $display("FAIL mid_rerun%0d got %b want %b", i, mem_timeout, i >= 5);
            else passed++;
        end
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_stall_no_fwd();
        test_load_use();
        test_forwarding();
        test_branch();
        test_saturation();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central hazard and sequencing controller for the 5-stage ARM-style pipeline.
- Drives freeze/flush controls for the PC, IF/ID and ID/EX stage registers, and forwarding selects for the EXE operand muxes.
- Contains a memory-wait FSM with timeout detection, plus saturating performance counters for stalls and flushes.

Parameters:
- CNT_W, 16, width of perf counters stall_cnt and flush_cnt.
- TIMEOUT, 255, MEM_WAIT cycles before mem_timeout asserts; legal range 1..2^16-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- forward_en  in  1  1 = forwarding enabled.
- id_src1, id_src2  in  4  ID-stage source register numbers.
- id_two_src  in  1  id_src2 is a real operand.
- exe_dest  in  4  ID/EX destination register.
- exe_wb_en, exe_mem_read  in  1  ID/EX write-back enable and load flag.
- mem_dest, mem_wb_en  in  4/1  EX/MEM destination and write-back enable.
- wb_dest, wb_wb_en  in  4/1  MEM/WB destination and write-back enable.
- exe_src1, exe_src2  in  4  src1_reg/src2_reg from the ID/EX register.
- branch_taken  in  1  branch resolved taken in EXE.
- mem_req  in  1  MEM stage has a load/store this cycle.
- mem_ready  in  1  memory controller ready.
- freeze_pc, freeze_if_id  out  1  hold PC and IF/ID.
- flush_if_id, flush_id_ex  out  1  bubble-insert into IF/ID and ID/EX.
- freeze_all  out  1  hold every stage register including ID/EX, EX/MEM, MEM/WB.
- sel_src1, sel_src2  out  2  forwarding select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back value.
- mem_timeout  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (rst=0, async): FSM=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0. All control outputs and selects are forced 0 while rst=0.
- Hazard detection (combinational):
  - m1 = exe_wb_en & exe_dest==id_src1; m2 likewise with id_src2 & id_two_src. mem-stage matches n1/n2 use mem_dest/mem_wb_en.
  - forward_en=0: hazard = m1|m2|n1|n2.
  - forward_en=1: hazard = exe_mem_read & (m1|m2).
- Forwarding:
  - Only when forward_en=1; otherwise 00.
  - sel_srcX=01 if mem_wb_en & mem_dest==exe_srcX; else 10 if wb_wb_en & wb_dest==exe_srcX; else 00.
  - EX/MEM wins over MEM/WB.
  - sel values are unaffected by freezes.
- Priority (per cycle):
  1. freeze_all = mem_req & ~mem_ready. When 1: freeze_pc=freeze_if_id=1, flush_*=0.
  2. Else if branch_taken: flush_if_id=flush_id_ex=1, freeze_*=0.
  3. Else if hazard: freeze_pc=freeze_if_id=1, flush_id_ex=1.
  4. Else all 0.
- FSM states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when freeze_all=1; wait_cnt<=1.
  - MEM_WAIT: wait_cnt increments each cycle freeze_all=1. When wait_cnt==TIMEOUT, mem_timeout<=1; it stays 1 until reset.
  - wait_cnt saturates at TIMEOUT.
  - MEM_WAIT -> RUN on the first cycle mem_ready=1 or mem_req=0; wait_cnt<=0.
  - freeze_all itself is combinational, with 0-cycle latency.
- Counters, updated at the clock edge:
  - stall_cnt +1 for each cycle with freeze_pc=1 (priority 1 or 3).
  - flush_cnt +1 for each cycle with priority-2 flush.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - branch_taken with hazard: flush wins, no stall.
  - branch_taken during freeze_all: ignored that cycle. The branch remains held in EXE and is acted on when freeze_all drops.
- Reset mid-MEM_WAIT returns to RUN immediately and clears the timeout.

Test Plan:
- forward_en=0, exe_dest=3, exe_wb_en=1, id_src1=3 -> freeze_pc=freeze_if_id=flush_id_ex=1; stall_cnt 0->1 next edge.
- forward_en=1, exe_mem_read=1, exe_dest=5=id_src2, id_two_src=1 -> stall for 1 cycle. Same with exe_mem_read=0 -> no stall.
- forward_en=1, exe_src1=7, mem_dest=7, mem_wb_en=1, wb_dest=7, wb_wb_en=1 -> sel_src1=01. With mem_wb_en=0 -> 10.
- branch_taken=1 concurrent with a hazard -> flush_if_id=flush_id_ex=1, freeze_pc=0; flush_cnt +1.
- TIMEOUT=4, mem_req=1, mem_ready=0 for 6 cycles -> freeze_all=1 throughout; mem_timeout=1 after 4th wait cycle. mem_ready=1 -> freeze_all=0, FSM RUN next edge, mem_timeout still 1.
- Pull rst low mid-MEM_WAIT -> all outputs 0 immediately; counters 0; after release, state RUN.
